// File: rtl/mem_stall_responder.sv
// mem_stall_responder
//   Memory-side responder for the pipeline's data-memory chip-select/stall
//   interface. A MEM-stage access is held off with stall while a req/ack
//   transaction runs on a slower backing memory. Stall then drops for exactly
//   one cycle (DONE) with dout valid, and the pipeline advances on that edge.
//   Misaligned accesses and backing-memory timeouts complete with an err pulse.
//   A pipeline flush (abort) during a transaction lets the req/ack handshake
//   finish without disturbing dout.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   abort               synchronous flush, discards the current access
//   cs, ren, wen        access strobes from MEM stage (ren wins over wen)
//   addr, din           byte address and store data
//   dout                load data, valid in the DONE cycle, held afterwards
//   stall               combinational freeze request to the pipeline
//   err                 one-cycle pulse on timeout or misaligned access
//   mem_req, mem_we     registered backing-memory request / write strobe
//   mem_addr, mem_wdata latched word address and store data
//   mem_ack, mem_rdata  backing-memory completion pulse and read data
module mem_stall_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  cs,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  stall,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    // Last counter value allowed in REQ; the timeout fires in that cycle, so a
    // request without ack occupies exactly TIMEOUT REQ cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_reg, state_next;
    logic [7:0]              cnt_reg;
    logic                    discard_reg;
    logic [DATA_WIDTH-1:0]   dout_reg;
    logic                    err_reg;
    logic                    mem_req_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;

    logic                    acc;
    logic                    start_ok;
    logic                    aligned;
    logic                    kill;
    logic                    timeout_hit;
    logic [ADDR_WIDTH-1:0]   word_addr;

    assign acc         = cs & (ren | wen);
    assign start_ok    = acc & ~abort;
    assign aligned     = (addr[1:0] == 2'b00);
    // A flush in the ack cycle itself must discard just like an earlier one.
    assign kill        = discard_reg | abort;
    assign timeout_hit = (cnt_reg == CNT_LAST);

    // Word address: byte-lane bits forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_word_addr
            if (gi < 2) begin : g_lane
                assign word_addr[gi] = 1'b0;
            end else begin : g_word
                assign word_addr[gi] = addr[gi];
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = aligned ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_next = kill ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: stall is combinational so the pipeline freezes in the
    // same cycle the access appears.
    always_comb begin
        stall = 1'b0;
        case (state_reg)
            ST_IDLE: stall = start_ok;
            ST_REQ:  stall = ~kill;
            default: stall = 1'b0;
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // Datapath registers. While in REQ, mem_we_reg still holds the access
    // type (it only drops when the transaction ends), so ~mem_we_reg marks a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= 8'd0;
            discard_reg   <= 1'b0;
            dout_reg      <= '0;
            err_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg     <= 8'd0;
                    discard_reg <= 1'b0;
                    if (start_ok) begin
                        if (aligned) begin
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= wen & ~ren;
                            mem_addr_reg  <= word_addr;
                            mem_wdata_reg <= din;
                        end else begin
                            err_reg <= 1'b1;
                            if (ren) begin
                                dout_reg <= ERR_DATA;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        discard_reg <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        cnt_reg     <= 8'd0;
                        discard_reg <= 1'b0;
                        if (!kill && !mem_we_reg) begin
                            dout_reg <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        // Give up on the backing memory; a discarded access
                        // retires silently.
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        cnt_reg     <= 8'd0;
                        discard_reg <= 1'b0;
                        if (!kill) begin
                            err_reg <= 1'b1;
                            if (!mem_we_reg) begin
                                dout_reg <= ERR_DATA;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    cnt_reg     <= 8'd0;
                    discard_reg <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = dout_reg;
    assign err       = err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_stall_responder.sv
// tb_mem_stall_responder
//   Directed bench for mem_stall_responder with TIMEOUT=4. Inputs change one
//   time unit after each rising edge; outputs are checked one unit later.
module tb_mem_stall_responder;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          abort;
    logic          cs;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          stall;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stall_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (4),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (abort),
        .cs       (cs),
        .ren      (ren),
        .wen      (wen),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .stall    (stall),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        cs   = 1'b1;
        ren  = r;
        wen  = w;
        addr = a;
        din  = d;
    endtask

    task automatic release_bus();
        cs  = 1'b0;
        ren = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        addr = '0; din = '0;
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        #2;
        // Reset state; stall held low in reset even with an access present
        chk1 ("rst_stall", stall, 1'b0);
        chk32("rst_dout", dout, 32'h0);
        chk1 ("rst_err", err, 1'b0);
        chk1 ("rst_req", mem_req, 1'b0);
        chk1 ("rst_we", mem_we, 1'b0);
        chk32("rst_addr", mem_addr, 32'h0);
        chk32("rst_wdata", mem_wdata, 32'h0);
        release_bus();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Read 0x100, ack in 3rd REQ cycle
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0); #1;
        chk1 ("rd_c0_stall", stall, 1'b1);
        chk1 ("rd_c0_req", mem_req, 1'b0);
        tick(); #1;
        chk1 ("rd_r1_req", mem_req, 1'b1);
        chk1 ("rd_r1_we", mem_we, 1'b0);
        chk32("rd_r1_addr", mem_addr, 32'h0000_0100);
        chk1 ("rd_r1_stall", stall, 1'b1);
        tick(); #1;
        chk1 ("rd_r2_req", mem_req, 1'b1);
        chk1 ("rd_r2_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678; #1;
        chk1 ("rd_r3_req", mem_req, 1'b1);
        chk1 ("rd_r3_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b0; #1;
        chk32("rd_done_dout", dout, 32'h1234_5678);
        chk1 ("rd_done_stall", stall, 1'b0);
        chk1 ("rd_done_req", mem_req, 1'b0);
        chk1 ("rd_done_err", err, 1'b0);
        tick();
        release_bus(); #1;
        chk1 ("rd_idle_stall", stall, 1'b0);
        chk32("rd_idle_dout", dout, 32'h1234_5678);

        // Write 0x204, ack after 1 cycle; dout must not change
        tick();
        access(1'b0, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5); #1;
        chk1 ("wr_c0_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000; #1;
        chk1 ("wr_r1_req", mem_req, 1'b1);
        chk1 ("wr_r1_we", mem_we, 1'b1);
        chk32("wr_r1_addr", mem_addr, 32'h0000_0204);
        chk32("wr_r1_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk1 ("wr_r1_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b0; #1;
        chk1 ("wr_done_stall", stall, 1'b0);
        chk32("wr_done_dout", dout, 32'h1234_5678);
        chk1 ("wr_done_we", mem_we, 1'b0);
        chk1 ("wr_done_req", mem_req, 1'b0);
        tick();
        release_bus();

        // Back-to-back: read 0x0 then write 0x4
        tick();
        access(1'b1, 1'b0, 32'h0000_0000, 32'h0); #1;
        chk1 ("b2b_rd_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        chk1 ("b2b_rd_req", mem_req, 1'b1);
        chk32("b2b_rd_addr", mem_addr, 32'h0000_0000);
        tick();
        mem_ack = 1'b0; #1;
        chk32("b2b_rd_dout", dout, 32'hCAFE_F00D);
        chk1 ("b2b_done_stall", stall, 1'b0);
        chk1 ("b2b_done_req", mem_req, 1'b0);
        tick();
        access(1'b0, 1'b1, 32'h0000_0004, 32'h1111_1111); #1;
        chk1 ("b2b_idle_req", mem_req, 1'b0);
        chk1 ("b2b_wr_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b1; #1;
        chk1 ("b2b_wr_req", mem_req, 1'b1);
        chk1 ("b2b_wr_we", mem_we, 1'b1);
        chk32("b2b_wr_addr", mem_addr, 32'h0000_0004);
        chk32("b2b_wr_wdata", mem_wdata, 32'h1111_1111);
        tick();
        mem_ack = 1'b0; #1;
        chk1 ("b2b_wr_done_stall", stall, 1'b0);
        chk32("b2b_wr_done_dout", dout, 32'hCAFE_F00D);
        tick();
        release_bus(); #1;
        chk1 ("b2b_end_req", mem_req, 1'b0);

        // Abort mid-REQ; a new access during discard waits for IDLE
        tick();
        access(1'b1, 1'b0, 32'h0000_0300, 32'h0); #1;
        chk1 ("ab_c0_stall", stall, 1'b1);
        tick(); #1;
        chk1 ("ab_r1_stall", stall, 1'b1);
        chk1 ("ab_r1_req", mem_req, 1'b1);
        tick();
        abort = 1'b1; #1;
        chk1 ("ab_r2_stall", stall, 1'b0);
        chk1 ("ab_r2_req", mem_req, 1'b1);
        tick();
        abort = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; #1;
        chk1 ("ab_r3_stall", stall, 1'b0);
        chk1 ("ab_r3_req", mem_req, 1'b1);
        chk32("ab_r3_addr", mem_addr, 32'h0000_0300);
        tick();
        mem_ack = 1'b0; #1;
        chk32("ab_idle_dout", dout, 32'hCAFE_F00D);
        chk1 ("ab_idle_req", mem_req, 1'b0);
        chk1 ("ab_idle_err", err, 1'b0);
        chk1 ("ab_new_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0400_0400; #1;
        chk1 ("ab_new_req", mem_req, 1'b1);
        chk32("ab_new_addr", mem_addr, 32'h0000_0400);
        tick();
        mem_ack = 1'b0; #1;
        chk32("ab_new_dout", dout, 32'h0400_0400);
        chk1 ("ab_new_done_stall", stall, 1'b0);
        tick();
        release_bus();

        // Abort while idle: access is not taken
        tick();
        access(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        abort = 1'b1; #1;
        chk1 ("ab_idle_only_stall", stall, 1'b0);
        tick();
        abort = 1'b0;
        release_bus(); #1;
        chk1 ("ab_idle_only_req", mem_req, 1'b0);

        // Timeout: read with no ack, 4 REQ cycles
        tick();
        access(1'b1, 1'b0, 32'h0000_0500, 32'h0); #1;
        chk1 ("to_c0_stall", stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk1 ($sformatf("to_r%0d_req", i + 1), mem_req, 1'b1);
            chk1 ($sformatf("to_r%0d_stall", i + 1), stall, 1'b1);
            chk1 ($sformatf("to_r%0d_err", i + 1), err, 1'b0);
        end
        tick(); #1;
        chk1 ("to_done_err", err, 1'b1);
        chk32("to_done_dout", dout, 32'hDEADBEEF);
        chk1 ("to_done_req", mem_req, 1'b0);
        chk1 ("to_done_stall", stall, 1'b0);
        tick();
        release_bus(); #1;
        chk1 ("to_idle_err", err, 1'b0);

        // Asynchronous reset in the middle of a request
        tick();
        access(1'b1, 1'b0, 32'h0000_0600, 32'h0); #1;
        chk1 ("ar_c0_stall", stall, 1'b1);
        tick(); #1;
        chk1 ("ar_r1_req", mem_req, 1'b1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk1 ("ar_req", mem_req, 1'b0);
        chk1 ("ar_stall", stall, 1'b0);
        chk32("ar_dout", dout, 32'h0);
        chk32("ar_addr", mem_addr, 32'h0);
        release_bus();
        tick();
        rst_n = 1'b1;
        tick();
        access(1'b1, 1'b0, 32'h0000_0700, 32'h0); #1;
        chk1 ("ar_new_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777; #1;
        chk32("ar_new_addr", mem_addr, 32'h0000_0700);
        tick();
        mem_ack = 1'b0; #1;
        chk32("ar_new_dout", dout, 32'h7777_7777);
        chk1 ("ar_new_done_stall", stall, 1'b0);
        tick();
        release_bus();

        // Misaligned write: err, dout unchanged, no memory request
        tick();
        access(1'b0, 1'b1, 32'h0000_0206, 32'h2222_2222); #1;
        chk1 ("mw_c0_stall", stall, 1'b1);
        chk1 ("mw_c0_req", mem_req, 1'b0);
        tick(); #1;
        chk1 ("mw_done_err", err, 1'b1);
        chk32("mw_done_dout", dout, 32'h7777_7777);
        chk1 ("mw_done_req", mem_req, 1'b0);
        chk1 ("mw_done_stall", stall, 1'b0);
        tick();
        release_bus(); #1;
        chk1 ("mw_idle_err", err, 1'b0);

        // Misaligned read: err, dout=ERR_DATA, one stall cycle
        tick();
        access(1'b1, 1'b0, 32'h0000_0102, 32'h0); #1;
        chk1 ("mr_c0_stall", stall, 1'b1);
        chk1 ("mr_c0_req", mem_req, 1'b0);
        tick(); #1;
        chk1 ("mr_done_err", err, 1'b1);
        chk32("mr_done_dout", dout, 32'hDEADBEEF);
        chk1 ("mr_done_req", mem_req, 1'b0);
        chk1 ("mr_done_stall", stall, 1'b0);
        tick();
        release_bus(); #1;
        chk1 ("mr_idle_err", err, 1'b0);

        // Stray ack outside REQ is ignored
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        tick();
        mem_ack = 1'b0; #1;
        chk32("stray_dout", dout, 32'hDEADBEEF);
        chk1 ("stray_req", mem_req, 1'b0);
        chk1 ("stray_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stall_responder.md
Name: mem_stall_responder

Overview:
- Memory-side responder for the pipeline's data-memory chip-select / stall interface.
- Accepts the MEM-stage access (cs, ren/wen, address, write data) and drives stall while it runs a req/ack transaction on a slower backing memory.
- Releases stall for exactly one cycle with read data valid, so the pipeline advances past the access.
- One instance serves the RAM port; a second, write-disabled instance can serve the ROM port.

Parameters:
ADDR_WIDTH, 32, CPU/backing memory address width (byte address)
DATA_WIDTH, 32, data word width
TIMEOUT, 255, max cycles in REQ waiting for mem_ack before error completion (8-bit counter, 1..255)
ERR_DATA, 32'hDEADBEEF, dout value returned on timeout or misaligned read

Ports:
clk  in  1  main clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous pipeline flush (ram_rst/rom_rst); discards the current access
cs  in  1  chip select from MEM stage
ren  in  1  read enable
wen  in  1  write enable (ren wins if both set)
addr  in  ADDR_WIDTH  byte address
din  in  DATA_WIDTH  store data
dout  out  DATA_WIDTH  load data, valid in DONE cycle, held afterwards
stall  out  1  freeze request to pipeline controller (combinational)
err  out  1  one-cycle pulse on timeout or misaligned access
mem_req  out  1  backing memory request, registered
mem_we  out  1  backing memory write strobe, registered
mem_addr  out  ADDR_WIDTH  latched word address (addr[1:0] forced 0)
mem_wdata  out  DATA_WIDTH  latched store data
mem_ack  in  1  backing memory completion, one-cycle pulse
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack

Behaviour:
- Reset (rst_n=0, async): state=IDLE, dout=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0, discard flag=0. stall=0 while in reset.
- Access condition: acc = cs & (ren | wen).
- States: IDLE, REQ, DONE.
- IDLE:
  - stall = acc & ~abort, combinational in the same cycle.
  - On acc & ~abort & addr[1:0]==0: latch mem_addr, mem_wdata, mem_we=wen&~ren; set mem_req=1; go to REQ.
  - On acc & ~abort & addr[1:0]!=0: no memory transaction; pulse err; dout=ERR_DATA if read, else unchanged; go to DONE.
- REQ:
  - stall=1 unless the discard flag is set.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - The counter increments each cycle.
  - On mem_ack: mem_req=0, mem_we=0; if read, dout<=mem_rdata; if discard flag set, go to IDLE, else go to DONE. Counter clears.
  - If the counter reaches TIMEOUT without mem_ack: drop mem_req, pulse err, dout=ERR_DATA if read, go to DONE.
- DONE: stall=0 for exactly one cycle (pipeline advances on this edge); go to IDLE. A new access is recognised only in IDLE, so the same access never issues twice.
- abort:
  - In IDLE or DONE: go to IDLE, stall=0.
  - In REQ: set the discard flag and drop stall the same cycle. mem_req stays high until mem_ack (req/ack protocol is never broken); read data is not written to dout; return to IDLE.
  - A new access arriving while the discard flag is set is ignored until IDLE.
- Minimum latency: access seen in cycle 0 (stall=1), mem_req=1 in cycle 1, ack in cycle 1, DONE in cycle 2. That gives 2 stall cycles; in general stall cycles = 1 + ack delay.
- mem_ack outside REQ is ignored.
- Reset during REQ aborts immediately: mem_req=0 asynchronously.

Test Plan:
- Read, ack latency 3: cs=1, ren=1, addr=0x100; mem_ack with rdata=0x12345678 in the 3rd REQ cycle -> mem_req high 3 cycles, stall high 4 cycles, DONE cycle dout=0x12345678, stall=0.
- Write: cs=1, wen=1, addr=0x204, din=0xA5A5A5A5; ack after 1 cycle -> mem_we=1, mem_addr=0x204, mem_wdata=0xA5A5A5A5; stall 2 cycles; dout unchanged.
- Back-to-back: read 0x0 then write 0x4 on consecutive advances -> two distinct transactions with an IDLE cycle between them, no duplicate mem_req.
- Abort mid-REQ: read in flight, abort=1 in 2nd REQ cycle -> stall falls that cycle, mem_req held until ack, dout keeps its old value, state returns to IDLE.
- Timeout / misaligned, TIMEOUT=4:
  - Read with no ack -> err pulse after 4 REQ cycles, dout=0xDEADBEEF.
  - Read at addr=0x102 -> no mem_req, err pulse, stall 1 cycle.
- Async reset mid-REQ: rst_n low between edges -> mem_req, stall, dout drop to 0 immediately; after release, a new read completes normally.
